// File: rtl/ram_rd_arbiter_pkg.sv
// ram_arb_pkg: shared constants for the sample-RAM read arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   REQ_SPI / REQ_LOOP      : requester ids (also the tag carried to vld)
//   RD_LAT_MAX              : deepest RAM read latency the return path supports
package ram_arb_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 4;

  localparam logic REQ_SPI  = 1'b0;
  localparam logic REQ_LOOP = 1'b1;
endpackage

// File: rtl/ram_rd_arbiter_if.sv
// ram_rd_arbiter_if: requester and RAM signals of the read arbiter.
//   req0/addr0/gnt0/vld0 : SPI readout engine
//   req1/addr1/gnt1/vld1 : loop playback engine
//   rd_data              : shared read data, qualified by vld0/vld1
//   ram_rd/ram_addr      : read strobe and address to the RAM
//   ram_data             : RAM output data
// Modports: slave = arbiter side, master = engines + RAM side.
interface ram_rd_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              vld0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              vld1;
  logic [DATA_W-1:0] rd_data;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport slave (
    input  req0, addr0, req1, addr1, ram_data,
    output gnt0, vld0, gnt1, vld1, rd_data, ram_rd, ram_addr
  );

  modport master (
    output req0, addr0, req1, addr1, ram_data,
    input  gnt0, vld0, gnt1, vld1, rd_data, ram_rd, ram_addr
  );
endinterface

// File: rtl/ram_rd_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   i_req  : request levels, bit0 = SPI, bit1 = loop
//   i_last : id of the most recent winner
//   o_gnt  : one-hot winner (or 0 when idle)
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // tie: whoever did not win last time goes now
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/ram_rd_arbiter.sv
// ram_rd_arbiter: shares the single sample-RAM read port between the SPI
// readout engine (requester 0) and the loop playback engine (requester 1).
//   clk, rst : system clock, synchronous active-high reset
//   bus      : requester handshakes, shared rd_data and the RAM port
// A grant decided in cycle N shows as gntX/ram_rd/ram_addr in N+1; the
// matching vldX and rd_data appear RD_LAT+1 cycles after the grant pulse.
module ram_rd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1            // 1..RD_LAT_MAX
)(
  input  logic              clk,
  input  logic              rst,
  ram_rd_arbiter_if.slave   bus
);
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic              w_win;
  logic [ADDR_W-1:0] w_addr;

  logic [1:0]        r_gnt;
  logic              r_ram_rd;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_last;
  // Stage 0 lines up with the grant pulse; stage RD_LAT lines up with the
  // cycle the RAM presents the data for that grant.
  logic [RD_LAT:0]   r_vld_pipe;
  logic [RD_LAT:0]   r_tag_pipe;
  logic [1:0]        r_vld;
  logic [DATA_W-1:0] r_rd_data;

  assign w_req = {bus.req1, bus.req0};

  rr_arb2 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_any  = |w_gnt;
  assign w_win  = w_gnt[REQ_LOOP];
  assign w_addr = (w_win == REQ_LOOP) ? bus.addr1 : bus.addr0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt      <= '0;
      r_ram_rd   <= 1'b0;
      r_ram_addr <= '0;
      r_last     <= REQ_LOOP;         // SPI wins the first tie
      r_vld_pipe <= '0;               // drops reads still in flight
      r_tag_pipe <= '0;
      r_vld      <= '0;
      r_rd_data  <= '0;
    end else begin
      r_gnt    <= w_gnt;
      r_ram_rd <= w_any;
      if (w_any) begin
        r_ram_addr <= w_addr;
        r_last     <= w_win;
      end
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_any};
      r_tag_pipe <= {r_tag_pipe[RD_LAT-1:0], w_win};
      r_vld      <= '0;
      if (r_vld_pipe[RD_LAT]) begin
        r_vld[r_tag_pipe[RD_LAT]] <= 1'b1;
        r_rd_data                 <= bus.ram_data;
      end
    end
  end

  assign bus.gnt0     = r_gnt[REQ_SPI];
  assign bus.gnt1     = r_gnt[REQ_LOOP];
  assign bus.vld0     = r_vld[REQ_SPI];
  assign bus.vld1     = r_vld[REQ_LOOP];
  assign bus.rd_data  = r_rd_data;
  assign bus.ram_rd   = r_ram_rd;
  assign bus.ram_addr = r_ram_addr;
endmodule
